// File: rtl/tp_mon_pkg.sv
// tp_mon_pkg: stretcher state type and default STRETCH/CNT_W constants shared by tp_event_monitor and tp_stretch_ch
package tp_mon_pkg;
  typedef enum logic {IDLE, HOLD} st_e;
  localparam int STRETCH_DEF = 16;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/tp_stretch_ch.sv
// tp_stretch_ch: one channel (clk, rst, evt, cnt_clr in; stretch, toggle, cnt, ovf out) with edge detect, retriggerable stretcher, toggle and saturating counter
module tp_stretch_ch
  import tp_mon_pkg::*;
#(
  parameter int STRETCH = STRETCH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             cnt_clr,
  output logic             stretch,
  output logic             toggle,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam int HW = $clog2(STRETCH);
  localparam logic [HW-1:0] RELOAD = HW'(STRETCH - 1);
  st_e state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic evt_q, hit;
  assign hit = evt & ~evt_q;
  assign stretch = state == HOLD;
  always_comb begin
    state_n = hit ? HOLD : (state == HOLD && hcnt == '0) ? IDLE : state;
    hcnt_n = hit ? RELOAD : (state == HOLD && hcnt != '0) ? hcnt - 1'b1 : hcnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt <= '0;
      evt_q <= 1'b1;
      toggle <= 1'b0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      evt_q <= evt;
      toggle <= toggle ^ hit;
      if (cnt_clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (hit) begin
        if (&cnt) ovf <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tp_event_monitor.sv
// tp_event_monitor: per-channel test-point conditioning (CLK, RST, EVT_IN, CNT_CLR, SEL in; TP_STRETCH, TP_TOGGLE, CNT_OUT, OVF out) with registered counter readout
module tp_event_monitor
  import tp_mon_pkg::*;
#(
  parameter int NCH = 8,
  parameter int STRETCH = STRETCH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCH-1:0]         EVT_IN,
  input  logic                   CNT_CLR,
  input  logic [$clog2(NCH)-1:0] SEL,
  output logic [NCH-1:0]         TP_STRETCH,
  output logic [NCH-1:0]         TP_TOGGLE,
  output logic [CNT_W-1:0]       CNT_OUT,
  output logic                   OVF
);
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0] ovf;
  logic sel_ok;
  assign sel_ok = int'(SEL) < NCH;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tp_stretch_ch #(.STRETCH(STRETCH), .CNT_W(CNT_W)) u_ch (
      .clk(CLK),
      .rst(RST),
      .evt(EVT_IN[i]),
      .cnt_clr(CNT_CLR),
      .stretch(TP_STRETCH[i]),
      .toggle(TP_TOGGLE[i]),
      .cnt(cnt[i]),
      .ovf(ovf[i])
    );
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_OUT <= '0;
      OVF <= 1'b0;
    end else begin
      CNT_OUT <= sel_ok ? cnt[SEL] : '0;
      OVF <= sel_ok && ovf[SEL];
    end
  end
endmodule

// File: tb/tb_tp_event_monitor.sv
// tb_tp_event_monitor: scoreboard bench for tp_event_monitor (default instance plus a CNT_W=4 instance for saturation)
module tb_tp_event_monitor;
  localparam int S_STR = 0, S_TOG = 1, S_CNT = 2, S_OVF = 3, S_CNT2 = 4, S_OVF2 = 5, S_STRV = 6, S_TOGV = 7;
  typedef struct {
    int cyc;
    int sig;
    int b;
    logic [15:0] val;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] evt = '1, evt2 = '1;
  logic cnt_clr = 1'b0, clr2 = 1'b0;
  logic [2:0] sel = '0, sel2 = '0;
  logic [7:0] str, tog, str2, tog2;
  logic [15:0] cnt_out;
  logic [3:0] cnt2;
  logic ovf, ovf2;
  exp_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] got;
  always #5 clk = ~clk;
  tp_event_monitor dut (
    .CLK(clk), .RST(rst), .EVT_IN(evt), .CNT_CLR(cnt_clr), .SEL(sel),
    .TP_STRETCH(str), .TP_TOGGLE(tog), .CNT_OUT(cnt_out), .OVF(ovf)
  );
  tp_event_monitor #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .EVT_IN(evt2), .CNT_CLR(clr2), .SEL(sel2),
    .TP_STRETCH(str2), .TP_TOGGLE(tog2), .CNT_OUT(cnt2), .OVF(ovf2)
  );
  function automatic void want(int c, int sig, int b, logic [15:0] v, string n);
    exp_q.push_back('{cyc: c, sig: sig, b: b, val: v, name: n});
  endfunction
  function automatic logic [15:0] obs(int sig, int b);
    case (sig)
      S_STR:   return {15'b0, str[b]};
      S_TOG:   return {15'b0, tog[b]};
      S_CNT:   return cnt_out;
      S_OVF:   return {15'b0, ovf};
      S_CNT2:  return {12'b0, cnt2};
      S_OVF2:  return {15'b0, ovf2};
      S_STRV:  return {8'b0, str};
      default: return {8'b0, tog};
    endcase
  endfunction
  task automatic test_reset();
    int c;
    c = cyc + 1;
    want(c + 1, S_STRV, 0, 16'd0, "rst_stretch");
    want(c + 1, S_TOGV, 0, 16'd0, "rst_toggle");
    want(c + 1, S_CNT, 0, 16'd0, "rst_cnt");
    want(c + 1, S_OVF, 0, 16'd0, "rst_ovf");
    want(c + 1, S_CNT2, 0, 16'd0, "rst_cnt4");
    want(c + 1, S_OVF2, 0, 16'd0, "rst_ovf4");
    for (int k = 2; k <= 10; k++) begin
      want(c + k, S_STRV, 0, 16'd0, "rel_stretch");
      want(c + k, S_TOGV, 0, 16'd0, "rel_toggle");
    end
    for (int k = 3; k <= 10; k++) want(c + k, S_CNT, 0, 16'd0, "rel_cnt");
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 1) rst = 1'b0;
      if (k == 3) begin evt = '0; evt2 = '0; end
      if (k >= 2 && k <= 9) sel = 3'(k - 2);
    end
  endtask
  task automatic test_single();
    int c;
    c = cyc + 1;
    want(c, S_STR, 0, 16'd0, "single_str_pre");
    want(c, S_TOG, 0, 16'd0, "single_tog_pre");
    for (int k = 1; k <= 18; k++) want(c + k, S_STR, 0, (k <= 16) ? 16'd1 : 16'd0, "single_str");
    want(c + 1, S_TOG, 0, 16'd1, "single_tog");
    want(c + 1, S_CNT, 0, 16'd0, "single_cnt_early");
    want(c + 2, S_CNT, 0, 16'd1, "single_cnt");
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 0) begin sel = 3'd0; evt[0] = 1'b1; end
      if (k == 1) evt[0] = 1'b0;
    end
  endtask
  task automatic test_retrigger();
    int c;
    c = cyc + 1;
    for (int k = 1; k <= 28; k++) want(c + k, S_STR, 1, (k <= 26) ? 16'd1 : 16'd0, "retrig_str");
    want(c + 10, S_TOG, 1, 16'd1, "retrig_tog_mid");
    want(c + 11, S_TOG, 1, 16'd0, "retrig_tog_end");
    want(c + 2, S_CNT, 0, 16'd1, "retrig_cnt1");
    want(c + 11, S_CNT, 0, 16'd1, "retrig_cnt1_hold");
    want(c + 12, S_CNT, 0, 16'd2, "retrig_cnt2");
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 0) sel = 3'd1;
      evt[1] = (k == 0 || k == 10);
    end
  endtask
  task automatic test_saturate();
    int c;
    c = cyc + 1;
    want(c + 2, S_CNT2, 0, 16'd1, "sat_cnt_first");
    want(c + 30, S_CNT2, 0, 16'd15, "sat_cnt_15");
    want(c + 30, S_OVF2, 0, 16'd0, "sat_ovf_before");
    want(c + 32, S_OVF2, 0, 16'd1, "sat_ovf_set");
    want(c + 34, S_CNT2, 0, 16'd15, "sat_cnt_final");
    want(c + 34, S_OVF2, 0, 16'd1, "sat_ovf_final");
    want(c + 37, S_CNT2, 0, 16'd15, "clr_cnt_lag");
    want(c + 37, S_OVF2, 0, 16'd1, "clr_ovf_lag");
    want(c + 38, S_CNT2, 0, 16'd0, "clr_cnt");
    want(c + 38, S_OVF2, 0, 16'd0, "clr_ovf");
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 0) sel2 = 3'd2;
      evt2[2] = (k % 2 == 0 && k <= 32);
      clr2 = (k == 36);
    end
  endtask
  task automatic test_clr_coincident();
    int c;
    c = cyc + 1;
    for (int k = 1; k <= 21; k++) want(c + k, S_STR, 3, (k <= 19) ? 16'd1 : 16'd0, "clr_ev_str");
    want(c + 1, S_TOG, 3, 16'd1, "clr_ev_tog1");
    want(c + 3, S_TOG, 3, 16'd1, "clr_ev_tog_hold");
    want(c + 4, S_TOG, 3, 16'd0, "clr_ev_tog2");
    want(c + 2, S_CNT, 0, 16'd1, "clr_ev_cnt_pre");
    want(c + 4, S_CNT, 0, 16'd1, "clr_ev_cnt_lag");
    want(c + 5, S_CNT, 0, 16'd0, "clr_ev_cnt");
    want(c + 6, S_CNT, 0, 16'd0, "clr_ev_cnt_stay");
    want(c + 8, S_CNT, 0, 16'd0, "clr_other_ch");
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 0) sel = 3'd3;
      if (k == 7) sel = 3'd1;
      evt[3] = (k == 0 || k == 3);
      cnt_clr = (k == 3);
    end
  endtask
  task automatic test_reset_mid();
    int c;
    c = cyc + 1;
    for (int k = 1; k <= 26; k++)
      want(c + k, S_STR, 4, ((k >= 1 && k <= 5) || (k >= 9 && k <= 24)) ? 16'd1 : 16'd0, "rmid_str");
    want(c + 6, S_STRV, 0, 16'd0, "rmid_strv");
    want(c + 6, S_TOGV, 0, 16'd0, "rmid_togv");
    want(c + 1, S_TOG, 4, 16'd1, "rmid_tog_first");
    want(c + 9, S_TOG, 4, 16'd1, "rmid_tog_after");
    want(c + 2, S_CNT, 0, 16'd1, "rmid_cnt_pre");
    want(c + 6, S_CNT, 0, 16'd0, "rmid_cnt_rst");
    want(c + 10, S_CNT, 0, 16'd1, "rmid_cnt_after");
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 0) sel = 3'd4;
      evt[4] = (k == 0 || k == 8);
      rst = (k == 5);
    end
  endtask
  task automatic test_back_to_back();
    int c;
    c = cyc + 1;
    for (int k = 1; k <= 22; k++) want(c + k, S_STR, 5, (k <= 20) ? 16'd1 : 16'd0, "b2b_str");
    want(c + 1, S_TOG, 5, 16'd1, "b2b_tog1");
    want(c + 3, S_TOG, 5, 16'd1, "b2b_tog_level");
    want(c + 4, S_TOG, 5, 16'd1, "b2b_tog_low");
    want(c + 5, S_TOG, 5, 16'd0, "b2b_tog2");
    want(c + 2, S_CNT, 0, 16'd1, "b2b_cnt1");
    want(c + 4, S_CNT, 0, 16'd1, "b2b_cnt_level");
    want(c + 6, S_CNT, 0, 16'd2, "b2b_cnt2");
    want(c + 7, S_CNT, 0, 16'd2, "b2b_sel_before");
    want(c + 8, S_CNT, 0, 16'd1, "b2b_sel_switch");
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk); cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].cyc == cyc) begin
          got = obs(exp_q[i].sig, exp_q[i].b);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", exp_q[i].name, cyc, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      if (k == 0) sel = 3'd5;
      if (k == 7) sel = 3'd4;
      evt[5] = (k <= 2 || k == 4);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_retrigger();
    test_saturate();
    test_clr_coincident();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
